// File: rtl/iob_cpu_iob_bridge.sv
// Bridges a native CPU request port onto N_SLV IOb target channels.
// One request in flight; a per-request timeout turns a silent target into an error completion.
module iob_cpu_iob_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int N_SLV  = 2,
    parameter int ISPLIT = 1,
    parameter int TOUT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,
    input  logic                    cpu_valid_i,
    input  logic                    cpu_instr_i,
    input  logic [ADDR_W-1:0]       cpu_addr_i,
    input  logic [DATA_W-1:0]       cpu_wdata_i,
    input  logic [DATA_W/8-1:0]     cpu_wstrb_i,
    output logic [DATA_W-1:0]       cpu_rdata_o,
    output logic                    cpu_ready_o,
    output logic                    cpu_err_o,
    output logic [N_SLV-1:0]        avalid_o,
    output logic [ADDR_W-1:0]       addr_o,
    output logic [DATA_W-1:0]       wdata_o,
    output logic [DATA_W/8-1:0]     wstrb_o,
    input  logic [N_SLV-1:0]        ready_i,
    input  logic [N_SLV-1:0]        rvalid_i,
    input  logic [N_SLV*DATA_W-1:0] rdata_i,
    output logic [1:0]              dbg_state_o,
    output logic [TOUT_W-1:0]       dbg_tout_o
);

    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    // Counter value whose increment reaches 2^TOUT_W-1, i.e. the last cycle before timing out.
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'((2 ** TOUT_W) - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic                r_write;
    logic [TOUT_W-1:0]   r_tout;
    logic [N_SLV-1:0]    r_avalid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_err;

    logic [SEL_W-1:0]    w_sel;
    logic                w_unmapped;
    logic [N_SLV-1:0]    w_onehot;
    logic                w_ready;
    logic                w_rvalid;
    logic [DATA_W-1:0]   w_rdata;

    // w_sel decodes the incoming request; w_ready/w_rvalid/w_rdata follow the latched channel.
    always_comb begin
        w_sel      = (ISPLIT != 0 && cpu_instr_i) ? '0 : cpu_addr_i[ADDR_W-1 -: SEL_W];
        w_unmapped = 1'b1;
        w_onehot   = '0;
        w_ready    = 1'b0;
        w_rvalid   = 1'b0;
        w_rdata    = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_unmapped  = 1'b0;
            end
            if (r_sel == SEL_W'(k)) begin
                w_ready  = ready_i[k];
                w_rvalid = rvalid_i[k];
                w_rdata  = rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_write  <= 1'b0;
            r_tout   <= '0;
            r_avalid <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_rdata  <= '0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
        end else if (cke_i) begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_valid_i) begin
                        r_addr  <= cpu_addr_i;
                        r_wdata <= cpu_wdata_i;
                        r_wstrb <= cpu_wstrb_i;
                        r_sel   <= w_sel;
                        r_write <= |cpu_wstrb_i;
                        r_tout  <= '0;
                        if (w_unmapped) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state  <= S_REQ;
                            r_avalid <= w_onehot;
                        end
                    end
                end
                S_REQ, S_WAIT_R: begin
                    r_tout <= r_tout + 1'b1;
                    // A target handshake in the same cycle as the limit still wins.
                    if (r_state == S_REQ && w_ready) begin
                        r_avalid <= '0;
                        if (r_write) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= S_WAIT_R;
                        end
                    end else if (r_state == S_WAIT_R && w_rvalid) begin
                        r_rdata <= w_rdata;
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (r_tout == TOUT_LAST) begin
                        r_avalid <= '0;
                        r_rdata  <= '0;
                        r_state  <= S_DONE;
                        r_ready  <= 1'b1;
                        r_err    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata_o = r_rdata;
    assign cpu_ready_o = r_ready;
    assign cpu_err_o   = r_err;
    assign avalid_o    = r_avalid;
    assign addr_o      = r_addr;
    assign wdata_o     = r_wdata;
    assign wstrb_o     = r_wstrb;
    assign dbg_state_o = r_state;
    assign dbg_tout_o  = r_tout;

endmodule

// File: tb/tb_iob_cpu_iob_bridge.sv
// Randomized bench for iob_cpu_iob_bridge: a driver plays CPU and IOb targets, a monitor
// checks every completion against expectations computed from the request plan.
module tb_iob_cpu_iob_bridge;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int N_SLV    = 3;
    localparam int TOUT_W   = 4;
    localparam int STRB_W   = DATA_W / 8;
    localparam int TOUT_CYC = (2 ** TOUT_W) - 1;
    localparam int NEVER    = 1000;
    localparam int EXP_W    = 1 + DATA_W + 32;

    logic                    clk = 1'b0;
    logic                    arst_n = 1'b0;
    logic                    cke = 1'b1;
    logic                    cpu_valid = 1'b0;
    logic                    cpu_instr = 1'b0;
    logic [ADDR_W-1:0]       cpu_addr = '0;
    logic [DATA_W-1:0]       cpu_wdata = '0;
    logic [STRB_W-1:0]       cpu_wstrb = '0;
    logic [DATA_W-1:0]       cpu_rdata_o;
    logic                    cpu_ready_o;
    logic                    cpu_err_o;
    logic [N_SLV-1:0]        avalid_o;
    logic [ADDR_W-1:0]       addr_o;
    logic [DATA_W-1:0]       wdata_o;
    logic [STRB_W-1:0]       wstrb_o;
    logic [N_SLV-1:0]        ready_i = '0;
    logic [N_SLV-1:0]        rvalid_i = '0;
    logic [N_SLV*DATA_W-1:0] rdata_i = '0;
    logic [1:0]              dbg_state_o;
    logic [TOUT_W-1:0]       dbg_tout_o;

    int unsigned       cyc_cnt = 0;
    int                checks = 0;
    int                errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [EXP_W-1:0]  mon_e;
    logic [DATA_W-1:0] model_rdata = '0;

    iob_cpu_iob_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV), .ISPLIT(1), .TOUT_W(TOUT_W)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .cpu_valid_i(cpu_valid), .cpu_instr_i(cpu_instr), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
        .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o), .cpu_err_o(cpu_err_o),
        .avalid_o(avalid_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .ready_i(ready_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .dbg_state_o(dbg_state_o), .dbg_tout_o(dbg_tout_o)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every completion pulse pops one expectation.
    always @(negedge clk) begin
        if (arst_n && cpu_ready_o) begin
            if (exp_q.size() == 0) begin
                check("ready_with_empty_queue", 64'(cpu_ready_o), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("cpu_err", 64'(cpu_err_o), 64'(mon_e[EXP_W-1]));
                check("cpu_rdata", 64'(cpu_rdata_o), 64'(mon_e[DATA_W+31:32]));
                check("done_cycle", 64'(cyc_cnt), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic do_reset();
        arst_n    = 1'b0;
        cke       = 1'b1;
        cpu_valid = 1'b0;
        ready_i   = '0;
        rvalid_i  = '0;
        repeat (3) step();
        check("rst_ready", 64'(cpu_ready_o), 64'd0);
        check("rst_err", 64'(cpu_err_o), 64'd0);
        check("rst_rdata", 64'(cpu_rdata_o), 64'd0);
        check("rst_avalid", 64'(avalid_o), 64'd0);
        check("rst_addr", 64'(addr_o), 64'd0);
        check("rst_wdata", 64'(wdata_o), 64'd0);
        check("rst_wstrb", 64'(wstrb_o), 64'd0);
        check("rst_tout", 64'(dbg_tout_o), 64'd0);
        arst_n      = 1'b1;
        model_rdata = '0;
    endtask

    // r: REQ cycle index carrying ready_i; v: WAIT_R cycle index carrying rvalid_i.
    task automatic run_txn(input logic instr, input logic [ADDR_W-1:0] addr,
                           input logic [STRB_W-1:0] wstrb, input logic [DATA_W-1:0] data,
                           input int r, input int v, input bit gap_req, input bit hold_extra);
        int               ch;
        bit               mapped;
        bit               is_write;
        bit               gap;
        bit               done;
        int               hs;
        int               lat;
        logic             err;
        logic [DATA_W-1:0] exp_rdata;
        logic [DATA_W-1:0] wdata;
        logic [N_SLV-1:0] one;
        logic [N_SLV-1:0] exp_av;
        int unsigned      due;

        wdata    = $urandom;
        ch       = instr ? 0 : int'(addr[ADDR_W-1:ADDR_W-2]);
        mapped   = ch < N_SLV;
        is_write = (wstrb != 0);
        hs       = is_write ? r : r + 1 + v;
        gap      = 1'b0;
        if (!mapped) begin
            err = 1'b1; exp_rdata = model_rdata; lat = 1;
        end else if (hs >= TOUT_CYC) begin
            err = 1'b1; exp_rdata = '0; lat = TOUT_CYC + 1;
        end else begin
            err = 1'b0; exp_rdata = is_write ? model_rdata : data; lat = hs + 2;
            gap = gap_req && !is_write;
        end
        if (gap) lat = lat + 5;
        model_rdata = exp_rdata;
        due = cyc_cnt + lat;
        exp_q.push_back({err, exp_rdata, due});

        cke       = 1'b1;
        cpu_valid = 1'b1;
        cpu_instr = instr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        step();

        one  = 1;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (gap && i == r + 1) begin
                check("gap_tout_before", 64'(dbg_tout_o), 64'(r + 1));
                cke      = 1'b0;
                ready_i  = '0;
                rvalid_i = '1;
                for (int k = 0; k < N_SLV; k++) rdata_i[k*DATA_W +: DATA_W] = 32'hBAD0_0BAD;
                repeat (5) step();
                check("gap_tout_held", 64'(dbg_tout_o), 64'(r + 1));
                check("gap_no_ready", 64'(cpu_ready_o), 64'd0);
                cke      = 1'b1;
                rvalid_i = '0;
            end
            exp_av = (mapped && i <= r && i < TOUT_CYC) ? (one << ch) : '0;
            check("avalid", 64'(avalid_o), 64'(exp_av));
            if (i == 0) begin
                check("addr_o", 64'(addr_o), 64'(addr));
                check("wdata_o", 64'(wdata_o), 64'(wdata));
                check("wstrb_o", 64'(wstrb_o), 64'(wstrb));
            end
            if (cpu_ready_o) begin
                done     = 1'b1;
                ready_i  = '0;
                rvalid_i = '0;
                if (hold_extra) begin
                    step();
                    cpu_valid = 1'b0;
                    check("done_valid_ignored_avalid", 64'(avalid_o), 64'd0);
                    check("done_valid_ignored_ready", 64'(cpu_ready_o), 64'd0);
                end else begin
                    cpu_valid = 1'b0;
                    step();
                end
            end else begin
                ready_i  = '0;
                rvalid_i = '0;
                for (int k = 0; k < N_SLV; k++) begin
                    rdata_i[k*DATA_W +: DATA_W] = $urandom;
                    if (k != ch) begin
                        ready_i[k]  = 1'($urandom_range(0, 1));
                        rvalid_i[k] = 1'($urandom_range(0, 1));
                    end
                end
                if (mapped) begin
                    if (i == r) ready_i[ch] = 1'b1;
                    if (!is_write && i == r + 1 + v) begin
                        rvalid_i[ch] = 1'b1;
                        rdata_i[ch*DATA_W +: DATA_W] = data;
                    end else if (i <= r) begin
                        rvalid_i[ch] = 1'($urandom_range(0, 1));
                    end
                end
                step();
            end
        end
        if (!done) begin
            check("completion_within_bound", 64'(cpu_ready_o), 64'd1);
            exp_q.delete();
            do_reset();
        end
        cpu_valid = 1'b0;
        ready_i   = '0;
        rvalid_i  = '0;
    endtask

    task automatic reset_mid_txn();
        cpu_valid = 1'b1;
        cpu_instr = 1'b0;
        cpu_addr  = 32'h4000_0020;
        cpu_wstrb = '0;
        cpu_wdata = $urandom;
        ready_i   = '0;
        step();
        step();
        check("mid_avalid_before_reset", 64'(avalid_o), 64'b010);
        arst_n = 1'b0;
        #2;
        check("mid_rst_avalid", 64'(avalid_o), 64'd0);
        check("mid_rst_ready", 64'(cpu_ready_o), 64'd0);
        check("mid_rst_rdata", 64'(cpu_rdata_o), 64'd0);
        check("mid_rst_addr", 64'(addr_o), 64'd0);
        cpu_valid = 1'b0;
        step();
        arst_n      = 1'b1;
        model_rdata = '0;
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic [STRB_W-1:0] s;
        logic              ins;
        int                r;
        do_reset();
        // Read on channel 1, ready at cycle 1, rvalid at cycle 2
        run_txn(1'b0, 32'h4000_0010, 4'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_0004, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0);
        // Instruction fetch whose address would otherwise pick channel 2
        run_txn(1'b1, 32'h8000_0000, 4'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 32'hC000_0000, 4'h0, 32'h0, 0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h4000_0000, 4'h0, 32'h5555_AAAA, NEVER, 0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h8000_0100, 4'h0, 32'h0F0F_0F0F, 1, 0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_0040, 4'h0, 32'hCAFE_F00D, 1, NEVER, 1'b0, 1'b0);
        run_txn(1'b0, 32'h4000_0008, 4'h0, 32'h600D_CAFE, 1, 2, 1'b1, 1'b0);
        run_txn(1'b0, 32'h8000_0000, 4'h3, 32'h0, 2, 0, 1'b0, 1'b1);
        reset_mid_txn();
        run_txn(1'b0, 32'h0000_0010, 4'h1, 32'h0, 0, 0, 1'b0, 1'b0);
        for (int n = 0; n < 150; n++) begin
            ins = ($urandom_range(0, 3) == 0);
            a   = $urandom;
            s   = (ins || $urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r   = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 5);
            run_txn(ins, a, s, $urandom, r, $urandom_range(0, 5),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_cpu_iob_bridge.md
IOB_CPU_IOB_BRIDGE -- requirements
Module: iob_cpu_iob_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: CPU and IOb address width.
REQ-002 Parameter DATA_W, default 32: data width, a multiple of 8.
REQ-003 Parameter N_SLV, default 2: IOb target channels, 1..16; SEL_W = max(1, clog2(N_SLV)).
REQ-004 Parameter ISPLIT, default 1: 1 routes every instruction fetch to channel 0.
REQ-005 Parameter TOUT_W, default 8: timeout counter width; timeout limit is 2^TOUT_W-1 cycles.
REQ-006 clk_i  in  1  single clock; all state updates on rising edge.
REQ-007 arst_n_i  in  1  reset, asynchronous and active-low.
REQ-008 cke_i  in  1  clock enable; when 0, all registers hold.
REQ-009 cpu_valid_i  in  1  native request valid, held until cpu_ready_o.
REQ-010 cpu_instr_i  in  1  request is an instruction fetch.
REQ-011 cpu_addr_i  in  ADDR_W  byte address.
REQ-012 cpu_wdata_i  in  DATA_W  write data.
REQ-013 cpu_wstrb_i  in  DATA_W/8  byte strobes; all zero means read.
REQ-014 cpu_rdata_o  out  DATA_W  read data, valid while cpu_ready_o=1.
REQ-015 cpu_ready_o  out  1  one-cycle completion pulse.
REQ-016 cpu_err_o  out  1  completion is an error (unmapped or timeout), qualified by cpu_ready_o.
REQ-017 avalid_o  out  N_SLV  one-hot per-channel IOb request valid.
REQ-018 addr_o / wdata_o / wstrb_o  out  ADDR_W / DATA_W / DATA_W/8  shared latched request fields.
REQ-019 ready_i / rvalid_i  in  N_SLV each  per-channel IOb accept / read-data valid.
REQ-020 rdata_i  in  N_SLV*DATA_W  per-channel read data; channel k occupies bits [k*DATA_W +: DATA_W].

Function
REQ-021 Channel select: 0 if ISPLIT=1 and cpu_instr_i=1; otherwise cpu_addr_i[ADDR_W-1 -: SEL_W].
REQ-022 FSM states: IDLE, REQ, WAIT_R, DONE.
REQ-023 IDLE with cpu_valid_i=1: latch address, write data, strobes, channel index and read/write flag; then go to REQ.
REQ-024 IDLE with cpu_valid_i=1 and channel index >= N_SLV: go directly to DONE with the error flag set; no avalid_o is raised.
REQ-025 REQ: avalid_o[sel]=1 and all other avalid_o bits 0. On ready_i[sel]=1, a write goes to DONE and a read goes to WAIT_R.
REQ-026 WAIT_R: on rvalid_i[sel]=1, register rdata_i of channel sel into cpu_rdata_o and go to DONE.
REQ-027 DONE: cpu_ready_o=1 for exactly one cycle, then go to IDLE. A cpu_valid_i seen in DONE is ignored; the next request is accepted only in IDLE.
REQ-028 Minimum latency, with the request seen at cycle 0: write completes with cpu_ready_o at cycle 2; read completes at cycle 3, assuming rvalid_i arrives one cycle after ready_i.
REQ-029 Timeout counter: cleared on entry to REQ, increments each cycle in REQ or WAIT_R. On reaching 2^TOUT_W-1, go to DONE with cpu_err_o=1 and cpu_rdata_o=0, and drop avalid_o.
REQ-030 rvalid_i on a channel other than sel, or outside WAIT_R, is ignored.
REQ-031 ready_i and rvalid_i both high in REQ for a read: transition to WAIT_R only; the rvalid_i is not consumed.
REQ-032 addr_o, wdata_o and wstrb_o are registered and change only on acceptance in IDLE.
REQ-033 cpu_rdata_o holds its last value except when updated per REQ-026 or REQ-029.
REQ-034 cpu_err_o is 0 on every successful completion.

Reset
REQ-035 arst_n_i=0 asynchronously forces: state IDLE, avalid_o=0, cpu_ready_o=0, cpu_err_o=0, cpu_rdata_o=0, addr_o/wdata_o/wstrb_o=0, timeout counter=0.
REQ-036 Reset asserted mid-transaction aborts that transaction with no completion pulse.
REQ-037 The first request after reset release is accepted in the first cycle in which arst_n_i=1 and cke_i=1.

Verification
REQ-038 N_SLV=2, data read, addr=0x8000_0010 (sel=1): ready_i[1] at cycle 1, rvalid_i[1] with 0xDEADBEEF at cycle 2 -> cpu_ready_o=1 at cycle 3, cpu_rdata_o=0xDEADBEEF, cpu_err_o=0.
REQ-039 Write, wstrb=0xF, addr=0x0000_0004: ready_i[0] at cycle 1 -> avalid_o=2'b01 during cycle 1, cpu_ready_o at cycle 2, no wait for rvalid_i.
REQ-040 Instruction fetch, addr=0x8000_0000, ISPLIT=1 -> avalid_o=2'b01 (not 2'b10).
REQ-041 N_SLV=3, addr top bits select 3 -> cpu_ready_o=1 and cpu_err_o=1 at cycle 1, avalid_o stays 0.
REQ-042 TOUT_W=4, ready_i held 0 -> cpu_err_o=1 and cpu_ready_o=1 after 15 cycles in REQ, cpu_rdata_o=0, avalid_o=0.
REQ-043 cke_i=0 for 5 cycles during WAIT_R with rvalid_i pulsed -> state and timeout counter hold, and the pulse is not captured.
